// File: rtl/micro_sequencer_if.sv
// Handshake and microcode bus between the micro_sequencer and its environment.
// The environment supplies the control ROM contents combinationally at rom_addr.
interface micro_sequencer_if;
   logic        start;
   logic [3:0]  cnt_init;
   logic        flag_a;
   logic        flag_b;
   logic [22:0] rom_data;
   logic [4:0]  rom_addr;
   logic [14:0] ctrl;
   logic        busy;
   logic        done;
   logic        err;

   modport master (
      output start, cnt_init, flag_a, flag_b, rom_data,
      input  rom_addr, ctrl, busy, done, err
   );

   modport slave (
      input  start, cnt_init, flag_a, flag_b, rom_data,
      output rom_addr, ctrl, busy, done, err
   );
endinterface

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: walks an external control ROM from address 0, issuing
// one microword per cycle, with conditional branches, a loop counter and a watchdog.
//
// state | meaning
// IDLE  | waiting for start, uPC holds last value
// RUN   | issuing one microword per cycle
// DONE  | one-cycle done (and err on abort) pulse
module micro_sequencer #(
   parameter int ROM_DEPTH = 18,
   parameter int WDOG_MAX  = 255
) (
   input  logic               clk,
   input  logic               reset,
   micro_sequencer_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [5:0] DEPTH_LIM = 6'(ROM_DEPTH);
   localparam logic [7:0] WDOG_LIM  = 8'(WDOG_MAX);

   state_t      state_q, state_d;
   logic [4:0]  upc_q, upc_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  wdog_q, wdog_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic [2:0]  cond;
   logic [4:0]  target;
   logic [14:0] word_ctrl;
   logic [4:0]  upc_inc;
   logic [4:0]  next_upc;
   logic        halt;
   logic        wdog_hit;
   logic        range_hit;
   logic        issue;

   assign cond      = bus.rom_data[22:20];
   assign target    = bus.rom_data[19:15];
   assign word_ctrl = bus.rom_data[14:0];
   assign upc_inc   = upc_q + 5'd1;

   always_comb begin
      next_upc = upc_inc;
      case (cond)
         3'b000:  next_upc = target;
         3'b001:  next_upc = bus.flag_a ? target : upc_inc;
         3'b010:  next_upc = bus.flag_b ? target : upc_inc;
         3'b011:  next_upc = (cnt_q == 4'd0) ? target : upc_inc;
         3'b100:  next_upc = target;
         default: next_upc = upc_inc;
      endcase
   end

   // Halt wins over both abort causes; a halting or aborting word is not issued.
   assign halt      = (cond == 3'b100) && (target == upc_q);
   assign wdog_hit  = (wdog_q >= WDOG_LIM);
   assign range_hit = ({1'b0, next_upc} >= DEPTH_LIM);
   assign issue     = (state_q == RUN) && !halt && !wdog_hit && !range_hit;

   always_comb begin
      state_d = state_q;
      upc_d   = upc_q;
      cnt_d   = cnt_q;
      wdog_d  = wdog_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.start) begin
               state_d = RUN;
               upc_d   = 5'd0;
               cnt_d   = bus.cnt_init;
               wdog_d  = 8'd0;
            end
         end
         RUN: begin
            if (halt) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else if (wdog_hit || range_hit) begin
               state_d = DONE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else begin
               upc_d  = next_upc;
               wdog_d = wdog_q + 8'd1;
               if (word_ctrl[14] && (cnt_q != 4'd0)) cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         upc_q   <= 5'd0;
         cnt_q   <= 4'd0;
         wdog_q  <= 8'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         upc_q   <= upc_d;
         cnt_q   <= cnt_d;
         wdog_q  <= wdog_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bus.rom_addr = upc_q;
   assign bus.ctrl     = issue ? word_ctrl : 15'h0000;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
endmodule
